// File: rtl/inc_share_arb_if.sv
// -----------------------------------------------------------------------------
// inc_share_arb_if
// Request/response bundle for inc_share_arb, the arbiter that shares one
// 20-bit incrementer between NREQ requesters.
//
// Signals:
//   req_valid  [NREQ]      requester i presents an operand
//   req_data   [NREQ*20]   operand of requester i in bits [20*i+19 : 20*i]
//   req_ready  [NREQ]      one-hot grant; operand i is taken this cycle
//   resp_valid             result available
//   resp_data  [20]        incremented operand
//   resp_cout              carry-out of the increment
//   resp_id    [2]         requester that owns the result
//   resp_ready             consumer accepts the result
//
// Modports:
//   slave  - the arbiter side (inc_share_arb)
//   master - the requester/consumer side
// -----------------------------------------------------------------------------
interface inc_share_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*20-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic [19:0]        resp_data;
    logic               resp_cout;
    logic [1:0]         resp_id;
    logic               resp_ready;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_cout,
        output resp_id,
        input  resp_ready
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_cout,
        input  resp_id,
        output resp_ready
    );
endinterface

// File: rtl/inc_share_arb.sv
// -----------------------------------------------------------------------------
// inc_share_arb
// Round-robin arbiter and sequencer sharing one combinational 20-bit
// incrementer between NREQ (2..4) requesters. A granted operand is
// registered, incremented in the following cycle, and the sum, carry-out and
// owner ID are held on the response channel until the consumer accepts them.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - inc_share_arb_if.slave: request valid/data/ready per requester,
//          response valid/data/cout/id with resp_ready backpressure
//
// Build option:
//   INC_SAT_EN - when defined, the increment saturates at 20'hFFFFF
//                (carry still reported); otherwise it wraps to 20'h00000.
// -----------------------------------------------------------------------------
module inc_share_arb #(
    parameter int NREQ = 4
) (
    input  logic          clk,
    input  logic          rst,
    inc_share_arb_if.slave bus
);
    localparam int W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic [W-1:0] op_q, op_d;
    logic [1:0]   id_q, id_d;
    logic [W-1:0] resp_data_q, resp_data_d;
    logic         resp_cout_q, resp_cout_d;
    logic [1:0]   resp_id_q, resp_id_d;

    logic            grant_found;
    logic [1:0]      grant_idx;
    logic [NREQ-1:0] grant_vec;
    logic [W-1:0]    grant_data;
    logic [W:0]      inc_res;

    // The shared incrementer: {carry, sum}. In the saturating build the sum
    // is clamped to all-ones while the carry still flags the overflow.
    function automatic logic [W:0] twenty_bit_inc(input logic [W-1:0] op);
        logic [W:0] s;
        s = {1'b0, op} + {{W{1'b0}}, 1'b1};
`ifdef INC_SAT_EN
        if (s[W]) begin
            s = {1'b1, {W{1'b1}}};
        end
`endif
        return s;
    endfunction

    // Round-robin search: first look at indices at or above rr_ptr, then
    // wrap to the ones below it. Indices >= NREQ are simply never scanned.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        grant_vec   = '0;
        grant_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && bus.req_valid[i] && (2'(i) >= rr_ptr_q)) begin
                grant_found  = 1'b1;
                grant_idx    = 2'(i);
                grant_vec[i] = 1'b1;
                grant_data   = bus.req_data[i*W +: W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && bus.req_valid[i]) begin
                grant_found  = 1'b1;
                grant_idx    = 2'(i);
                grant_vec[i] = 1'b1;
                grant_data   = bus.req_data[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        id_d        = id_q;
        resp_data_d = resp_data_q;
        resp_cout_d = resp_cout_q;
        resp_id_d   = resp_id_q;
        inc_res     = twenty_bit_inc(op_q);

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_d     = grant_data;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = inc_res[W-1:0];
                resp_cout_d = inc_res[W];
                resp_id_d   = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grants are only offered while idle; the response registers are only
    // written in EXEC, so they hold steady for as long as RESP is stalled.
    assign bus.req_ready  = (state_q == IDLE) ? grant_vec : '0;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_cout  = resp_cout_q;
    assign bus.resp_id    = resp_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd0;
            resp_data_q <= '0;
            resp_cout_q <= 1'b0;
            resp_id_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            resp_cout_q <= resp_cout_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // Operand and owner are only meaningful after a grant, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        id_q <= id_d;
    end
endmodule

// File: doc/inc_share_arb.md
# inc_share_arb

Round-robin arbiter and sequencer that shares one combinational 20-bit incrementer (`twentyBitInc`) between up to `NREQ` requesters, such as the PC update path and loop/address counters. Each requester hands over a 20-bit operand with a valid/ready handshake. The block registers the operand, drives it through the shared incrementer, and returns the registered sum, carry-out and requester ID on a single response channel. It sits between the requesting units and the one incrementer instance in the datapath.

## Interface
- `NREQ`, 4, number of requesters; legal values 2..4.
- Operand width is fixed at 20 bits (matches `twentyBitInc`).

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i presents an operand.
- `req_data`  in  NREQ*20  operand of requester i in bits [20*i+19 : 20*i].
- `req_ready`  out  NREQ  one-hot grant; bit i high means operand i is accepted this cycle.
- `resp_valid`  out  1  result available.
- `resp_data`  out  20  incremented operand.
- `resp_cout`  out  1  carry-out of the increment.
- `resp_id`  out  2  index of the requester that owns the result.
- `resp_ready`  in  1  consumer accepts the result.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, grant exactly one requester by round-robin.
  - Priority search starts at `rr_ptr` and proceeds upward, wrapping modulo `NREQ`.
  - `req_ready` is combinational and asserted only in IDLE, for the granted index.
  - On the grant edge: `op_reg` <= that requester's operand, `id_reg` <= its index, `rr_ptr` <= (granted+1) mod `NREQ`, state goes to EXEC.
  - If no request is valid, stay in IDLE and leave `rr_ptr` unchanged.
- **EXEC**
  - `op_reg` drives the incrementer.
  - On the edge: `resp_data` <= sum, `resp_cout` <= carry, `resp_id` <= `id_reg`, state goes to RESP.
- **RESP**
  - `resp_valid` is 1 and all response outputs hold stable.
  - When `resp_ready` is 1: go to IDLE and clear `resp_valid`.
  - When `resp_ready` is 0: stay in RESP. This is backpressure, held indefinitely.
  - `req_ready` is all zeros in EXEC and RESP. Requesters must hold `req_valid` and `req_data` until granted.
- **Arithmetic:** `resp_data` = (`op_reg` + 1) mod 2^20; `resp_cout` = 1 only when `op_reg` = 20'hFFFFF.
- **Requester index ≥ `NREQ`:** ignored, and never granted.
- **`req_valid` dropped before grant:** the request is not granted and no state changes.

## Timing
- **Reset values** (at the first edge with `rst`=1):
  - State IDLE, `rr_ptr`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_data`=20'h0, `resp_cout`=0, `resp_id`=0.
- **Latency:** grant edge → `resp_valid` high 2 edges later (IDLE→EXEC→RESP).
- **Throughput:** with `resp_ready` tied high, at most one operand per 3 cycles.
- **Reset mid-operation:** `rst` in EXEC or RESP discards the operand and result. No response is emitted, and `rr_ptr` returns to 0.
- **Reset priority:** `rst` overrides everything, including a simultaneous grant or `resp_ready`.
- **Simultaneous requests:** the requester nearest above `rr_ptr` (inclusive, wrapping) wins; the others wait.
- **Response exit:** the `resp_ready`=1 edge in RESP returns the FSM to IDLE. A new grant can occur in the very next cycle.

## Configuration
- Macro `INC_SAT_EN`.
- **Defined:** saturating increment. For operand 20'hFFFFF, `resp_data`=20'hFFFFF and `resp_cout`=1. All other operands are unchanged from normal behaviour.
- **Undefined:** wrapping increment. For operand 20'hFFFFF, `resp_data`=20'h00000 and `resp_cout`=1.
- The handshake, timing and arbitration are identical in both builds.

## Test plan
- **Reset:** `rst`=1 for 2 cycles.
  - Required: all outputs at reset values.
  - Then requester 0 sends 20'h00000 → `req_ready`=4'b0001 for 1 cycle, `resp_valid` 2 edges later, `resp_data`=20'h00001, `resp_cout`=0, `resp_id`=0.
- **Carry boundary:** requester 1 sends 20'h7FFFF → 20'h80000, cout=0. Then it sends 20'hFFFFF → 20'h00000, cout=1 (20'hFFFFF, cout=1 with `INC_SAT_EN`).
- **Round-robin:** all 4 requesters valid continuously, `resp_ready`=1.
  - Required: grant order 0,1,2,3,0, and `resp_id` follows the same sequence.
  - Each result equals its operand+1.
- **Backpressure:** `resp_ready`=0 for 10 cycles while requester 2 is valid.
  - Required: `resp_valid` and `resp_data` stay stable throughout, and `req_ready` stays 0.
  - Then `resp_ready`=1 for one edge → IDLE, followed by a regrant.
- **Reset mid-operation:** assert `rst` during EXEC with operand 20'h00010.
  - Required: no `resp_valid` pulse, `rr_ptr`=0.
  - A subsequent simultaneous request from 0 and 3 grants 0 first.
